// File: rtl/serial_word_capture_if.sv
// Handshake bundle between a serial bit source/word sink and serial_word_capture.
// The master drives the serial stream and out_ready; the slave returns the assembled word.
interface serial_word_capture_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             bit_in;
    logic             bit_valid;
    logic             out_ready;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             busy;
    logic             overrun;

    modport master (
        output start, bit_in, bit_valid, out_ready,
        input  word_out, word_valid, busy, overrun
    );

    modport slave (
        input  start, bit_in, bit_valid, out_ready,
        output word_out, word_valid, busy, overrun
    );
endinterface

// File: rtl/serial_word_capture.sv
// Collects WIDTH LSB-first serial bits into a word and holds it under a valid/ready
// handshake; a bit arriving while a finished word waits sets a sticky overrun flag.
module serial_word_capture #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
) (
    input  logic                 clk,
    input  logic                 CLR,
    serial_word_capture_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_HOT0  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LAST_BIT  = CW'(WIDTH - 1);

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] word_r;
    logic             word_valid_r;
    logic             busy_r;
    logic             overrun_r;
    logic [WIDTH-1:0] shift_nxt_s;

    // Shift register is cleared at every frame start, so OR-ing the new bit into
    // position cnt_r is enough to place it.
    always_comb begin
        shift_nxt_s = shift_r;
        if (bus.bit_in) begin
            shift_nxt_s = shift_r | (ONE_HOT0 << cnt_r);
        end else begin
            shift_nxt_s = shift_r;
        end
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (CLR) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            shift_r      <= {WIDTH{1'b0}};
            word_r       <= {WIDTH{1'b0}};
            word_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r <= SHIFT;
                        busy_r  <= 1'b1;
                        cnt_r   <= {CW{1'b0}};
                        shift_r <= {WIDTH{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bus.start) begin
                        cnt_r   <= {CW{1'b0}};
                        shift_r <= {WIDTH{1'b0}};
                    end else if (bus.bit_valid) begin
                        shift_r <= shift_nxt_s;
                        if (cnt_r == LAST_BIT) begin
                            state_r      <= HOLD;
                            word_r       <= shift_nxt_s;
                            word_valid_r <= 1'b1;
                            busy_r       <= 1'b0;
                            cnt_r        <= {CW{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                HOLD: begin
                    // Dropped bit still flags overrun even in the handshake cycle.
                    if (bus.bit_valid) begin
                        overrun_r <= 1'b1;
                    end else begin
                        overrun_r <= overrun_r;
                    end
                    if (bus.out_ready) begin
                        word_valid_r <= 1'b0;
                        if (bus.start) begin
                            state_r <= SHIFT;
                            busy_r  <= 1'b1;
                            cnt_r   <= {CW{1'b0}};
                            shift_r <= {WIDTH{1'b0}};
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= {CW{1'b0}};
                    shift_r      <= {WIDTH{1'b0}};
                    word_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.word_out   = word_r;
    assign bus.word_valid = word_valid_r;
    assign bus.busy       = busy_r;
    assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_serial_word_capture.sv
// Directed self-checking bench for serial_word_capture (WIDTH=8): reset, basic,
// stalled, restarted, back-to-back and overrun frames.
module tb_serial_word_capture;
    logic clk;
    logic CLR;
    int   checks;
    int   errors;

    serial_word_capture_if #(.WIDTH(8)) bus ();

    serial_word_capture #(.WIDTH(8), .CW(5)) dut (
        .clk (clk),
        .CLR (CLR),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start cycle also drives a bit that must be ignored.
    task automatic do_start();
        bus.start     = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    endtask

    // Send 8 bits LSB first; gap i%(maxgap+1) idle cycles before bit i.
    task automatic send_bits(input logic [7:0] w, input int maxgap);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < (i % (maxgap + 1)); g++) begin
                bus.bit_valid = 1'b0;
                tick();
                chk("busy_gap", {31'd0, bus.busy}, 32'd1);
            end
            bus.bit_valid = 1'b1;
            bus.bit_in    = w[i];
            tick();
            bus.bit_valid = 1'b0;
            bus.bit_in    = 1'b0;
            if (i < 7) begin
                chk("valid_low_mid", {31'd0, bus.word_valid}, 32'd0);
                chk("busy_mid", {31'd0, bus.busy}, 32'd1);
            end else begin
                chk("valid_after_last", {31'd0, bus.word_valid}, 32'd1);
                chk("busy_after_last", {31'd0, bus.busy}, 32'd0);
                chk("word_after_last", {24'd0, bus.word_out}, {24'd0, w});
            end
        end
    endtask

    task automatic handshake(input logic [7:0] w);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("valid_drop", {31'd0, bus.word_valid}, 32'd0);
        chk("word_kept", {24'd0, bus.word_out}, {24'd0, w});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        CLR           = 1'b1;
        bus.start     = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        CLR = 1'b0;
        chk("rst_word", {24'd0, bus.word_out}, 32'd0);
        chk("rst_valid", {31'd0, bus.word_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);

        // Reset mid-frame discards partial bits.
        do_start();
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        tick();
        tick();
        bus.bit_valid = 1'b0;
        CLR = 1'b1;
        tick();
        tick();
        CLR = 1'b0;
        chk("clr_busy", {31'd0, bus.busy}, 32'd0);
        chk("clr_valid", {31'd0, bus.word_valid}, 32'd0);
        chk("clr_word", {24'd0, bus.word_out}, 32'd0);
        chk("clr_overrun", {31'd0, bus.overrun}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'b1;
            tick();
            bus.bit_valid = 1'b0;
            tick();
        end
        chk("idle_bits_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_bits_valid", {31'd0, bus.word_valid}, 32'd0);
        chk("idle_bits_word", {24'd0, bus.word_out}, 32'd0);
        chk("idle_bits_overrun", {31'd0, bus.overrun}, 32'd0);

        // Basic frame held for 5 cycles.
        do_start();
        send_bits(8'h0B, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid", {31'd0, bus.word_valid}, 32'd1);
            chk("hold_word", {24'd0, bus.word_out}, 32'h0B);
        end
        handshake(8'h0B);
        chk("idle_after_hs_busy", {31'd0, bus.busy}, 32'd0);

        // Stalled frame, gaps 0..3.
        do_start();
        send_bits(8'h0B, 3);
        handshake(8'h0B);

        // Restart after 5 ones; restart cycle carries an ignored bit.
        do_start();
        for (int k = 0; k < 5; k++) begin
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'b1;
            tick();
        end
        bus.bit_valid = 1'b0;
        do_start();
        send_bits(8'h0D, 0);
        handshake(8'h0D);

        // Back-to-back frames through a start in the handshake cycle.
        do_start();
        send_bits(8'h15, 0);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk("b2b_valid_drop", {31'd0, bus.word_valid}, 32'd0);
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        send_bits(8'h22, 0);
        handshake(8'h22);

        // Start without out_ready in HOLD is ignored.
        do_start();
        send_bits(8'hFF, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("hold_start_ignored", {31'd0, bus.word_valid}, 32'd1);
        chk("hold_start_busy", {31'd0, bus.busy}, 32'd0);

        // Overrun.
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b0;
        tick();
        bus.bit_valid = 1'b0;
        chk("ovr_set", {31'd0, bus.overrun}, 32'd1);
        chk("ovr_word", {24'd0, bus.word_out}, 32'hFF);
        chk("ovr_valid", {31'd0, bus.word_valid}, 32'd1);
        handshake(8'hFF);
        do_start();
        send_bits(8'h01, 1);
        chk("ovr_sticky", {31'd0, bus.overrun}, 32'd1);
        handshake(8'h01);
        chk("ovr_sticky2", {31'd0, bus.overrun}, 32'd1);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("ovr_cleared", {31'd0, bus.overrun}, 32'd0);
        chk("final_word", {24'd0, bus.word_out}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_word_capture.md
Name: serial_word_capture

Overview:
- Receiving end of the one-bit-per-clock serial streams produced by the registered logic-cell datapath (Fibonacci terms emitted LSB first from a registered cell output).
- Collects WIDTH serial bits into a parallel word and presents it downstream with a valid/ready handshake.
- Framed by a start strobe; flags overrun when bits arrive while a completed word is still waiting to be taken.

Parameters:
- WIDTH, 8, number of bits per word (2..32).
- CW, 5, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- CLR  in  1  reset; synchronous, active-high.
- start  in  1  frame-start strobe; one cycle wide.
- bit_in  in  1  serial data bit, LSB first.
- bit_valid  in  1  bit_in is valid this cycle.
- out_ready  in  1  downstream accepts word_out this cycle.
- word_out  out  WIDTH  assembled word, bit 0 = first bit received.
- word_valid  out  1  word_out holds a complete word.
- busy  out  1  frame in progress (state SHIFT).
- overrun  out  1  sticky; a bit arrived while in HOLD.

Behaviour:
- Reset (CLR=1 at a rising edge): state=IDLE; word_out=0, word_valid=0, busy=0, overrun=0, bit counter=0. CLR overrides every other input, including mid-frame and in HOLD; any partial or held word is discarded.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - start=1 -> SHIFT next cycle; counter cleared.
  - bit_valid is ignored, including in the start cycle.
  - First data bit is sampled no earlier than the cycle after start.
- SHIFT:
  - busy=1.
  - On each bit_valid=1: shift register takes bit_in into position counter (LSB first); counter increments.
  - bit_valid=0 stalls; there is no timeout.
  - When the WIDTH-th bit is accepted: the next cycle shows state=HOLD, word_valid=1, word_out = the full word, busy=0.
  - Latency from last bit to word_valid is 1 clock.
- start during SHIFT:
  - Restarts the frame; counter cleared, partial bits discarded.
  - A bit_valid in the same cycle as start is ignored.
- HOLD:
  - word_valid=1; word_out is stable until the handshake completes.
  - Handshake: word_valid & out_ready at a rising edge -> word_valid=0 next cycle.
  - Next state is IDLE, or SHIFT if start=1 in the same handshake cycle (back-to-back frames, no bubble).
  - start without out_ready is ignored.
  - bit_valid=1 while in HOLD: bit dropped, overrun set to 1 next cycle.
- overrun stays 1 until CLR; it does not block further frames.
- word_out is not cleared on handshake; it keeps its last value until overwritten by the next completed frame.
- Counter never exceeds WIDTH; no wrap-around inside a frame.

Test Plan:
- Reset: assert CLR for 2 cycles mid-SHIFT -> word_out=0, word_valid=0, busy=0, overrun=0; 3 further bit_valid pulses in IDLE produce no change.
- Basic frame (WIDTH=8): start, then bits 1,1,0,1,0,0,0,0 on consecutive cycles with out_ready=0 -> word_valid=1 one cycle after the 8th bit, word_out=8'h0B, held stable for 5 cycles until out_ready=1, then word_valid=0.
- Stalled frame: same 8'h0B bits with bit_valid gaps of 0–3 idle cycles between them -> identical word 8'h0B; busy=1 throughout the frame.
- Restart: start, 5 bits of 1, start again, then 8 bits giving 8'h0D -> word_out=8'h0D with no residue from the aborted frame.
- Back-to-back: frame 8'h15, handshake with start=1 in the same cycle, then frame 8'h22 -> second word_valid rises exactly 1 cycle after its 8th bit; no cycle is lost between frames.
- Overrun: complete frame 8'hFF, hold out_ready=0, pulse bit_valid once -> overrun=1 next cycle, word_out remains 8'hFF; a later frame 8'h01 captures correctly with overrun still 1 until CLR.
